// File: rtl/vend_pkg.sv
// Shared types and default constants for the vending dispense controller.
// Holds the FSM state enum plus default prices, credit limit and pulse length.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DISP_COFFEE = 2'd1,
    DISP_SPRITE = 2'd2
  } vend_state_t;

  localparam int DEF_COFFEE_PRICE = 1;
  localparam int DEF_SPRITE_PRICE = 2;
  localparam int DEF_MAX_CREDIT   = 3;
  localparam int DEF_DISP_CYCLES  = 4;
  localparam int CREDIT_W         = 2;

endpackage

// File: rtl/vend_edge_det.sv
// Rising-edge detector: rise[i] is high in a cycle where d[i] is 1 and was 0
// at the previous clock. Ports: clk, rst_n (async low), d[N], rise[N].
module vend_edge_det #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] rise
);

  logic [N-1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= '0;
    else        hist <= d;
  end

  assign rise = d & ~hist;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller: coin credit, per-product pending requests,
// round-robin grant and fixed-length chute pulse. Ports: clk, reset (async
// low), C/F/P event levels, led/o/credit/busy/coin_rej outputs. Optional
// coin return (R in, chg out) is built when VEND_CHANGE_EN is defined.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int COFFEE_PRICE = DEF_COFFEE_PRICE,
  parameter int SPRITE_PRICE = DEF_SPRITE_PRICE,
  parameter int MAX_CREDIT   = DEF_MAX_CREDIT,
  parameter int DISP_CYCLES  = DEF_DISP_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       C,
  input  logic       F,
  input  logic       P,
`ifdef VEND_CHANGE_EN
  input  logic       R,
  output logic       chg,
`endif
  output logic [1:0] led,
  output logic [1:0] o,
  output logic [1:0] credit,
  output logic       busy,
  output logic       coin_rej
);

  localparam int CNT_W =
    (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  vend_state_t state;
  logic [1:0]  pend;
  logic [1:0]  pend_nxt;
  logic        rr_coffee;
  logic [CNT_W-1:0] cnt;

  logic [1:0]  afford;
  logic [1:0]  cand;
  logic [1:0]  gnt;
  logic        hold;
  logic        coin_ok;
  logic        rej_nxt;
  logic [3:0]  acc;
  logic [1:0]  credit_nxt;

  logic        rise_c;
  logic        rise_f;
  logic        rise_p;
  logic        ret_act;
  logic        r_start;
  logic        chg_dec;

`ifdef VEND_CHANGE_EN
  localparam int NEV = 4;
  logic [NEV-1:0] ev_in;
  logic [NEV-1:0] ev;
  assign ev_in = {R, P, F, C};
`else
  localparam int NEV = 3;
  logic [NEV-1:0] ev_in;
  logic [NEV-1:0] ev;
  assign ev_in = {P, F, C};
`endif

  vend_edge_det #(
    .N (NEV)
  ) u_edge (
    .clk   (clk),
    .rst_n (reset),
    .d     (ev_in),
    .rise  (ev)
  );

  assign rise_c = ev[0];
  assign rise_f = ev[1];
  assign rise_p = ev[2];

`ifdef VEND_CHANGE_EN
  // Return pays one credit per pulse, pulses on alternate clocks.
  assign r_start = ev[3] & (state == IDLE) & ~ret_act
                 & (credit != '0);
  assign chg_dec = r_start | (ret_act & ~chg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_act <= 1'b0;
      chg     <= 1'b0;
    end else begin
      chg <= chg_dec;
      if (r_start)
        ret_act <= 1'b1;
      else if (ret_act && chg && credit == '0)
        ret_act <= 1'b0;
    end
  end
`else
  assign ret_act = 1'b0;
  assign r_start = 1'b0;
  assign chg_dec = 1'b0;
`endif

  assign led = afford;

  always_comb begin
    afford[0] = int'(credit) >= COFFEE_PRICE;
    afford[1] = int'(credit) >= SPRITE_PRICE;
    hold      = ret_act | r_start;
    cand      = pend & afford;
    gnt       = 2'b00;
    if (state == IDLE && !hold) begin
      unique case (1'b1)
        (cand == 2'b11): gnt = rr_coffee ? 2'b01 : 2'b10;
        (cand == 2'b01): gnt = 2'b01;
        (cand == 2'b10): gnt = 2'b10;
        default:         gnt = 2'b00;
      endcase
    end
    coin_ok = rise_c & ~hold
            & (credit != CREDIT_W'(MAX_CREDIT));
    rej_nxt = rise_c & ~hold
            & (credit == CREDIT_W'(MAX_CREDIT));
    // Grant is only issued when affordable, so no underflow.
    acc = 4'(credit);
    if (coin_ok) acc = acc + 4'd1;
    if (gnt[0])  acc = acc - 4'(COFFEE_PRICE);
    if (gnt[1])  acc = acc - 4'(SPRITE_PRICE);
    if (chg_dec) acc = acc - 4'd1;
    credit_nxt = acc[1:0];
    // Unaffordable pending flags drop at grant time.
    pend_nxt = pend;
    if (r_start)
      pend_nxt = 2'b00;
    else if (state == IDLE && !ret_act)
      pend_nxt = cand & ~gnt;
    if (!hold) begin
      if (rise_f && afford[0]) pend_nxt[0] = 1'b1;
      if (rise_p && afford[1]) pend_nxt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      credit    <= '0;
      pend      <= '0;
      rr_coffee <= 1'b1;
      o         <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
      coin_rej  <= 1'b0;
    end else begin
      credit   <= credit_nxt;
      pend     <= pend_nxt;
      coin_rej <= rej_nxt;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            gnt[0]: begin
              state     <= DISP_COFFEE;
              o         <= 2'b01;
              busy      <= 1'b1;
              cnt       <= CNT_W'(DISP_CYCLES - 1);
              rr_coffee <= 1'b0;
            end
            gnt[1]: begin
              state     <= DISP_SPRITE;
              o         <= 2'b10;
              busy      <= 1'b1;
              cnt       <= CNT_W'(DISP_CYCLES - 1);
              rr_coffee <= 1'b1;
            end
            default: ;
          endcase
        end
        DISP_COFFEE, DISP_SPRITE: begin
          if (cnt == '0) begin
            state <= IDLE;
            o     <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Testbench for vend_dispense_ctrl: directed scenarios plus random C/F/P
// traffic compared against a purchase-level reference model.
module tb_vend_dispense_ctrl;
  import vend_pkg::*;

  localparam int CP = 1;
  localparam int SP = 2;
  localparam int MX = 3;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       C = 1'b0;
  logic       F = 1'b0;
  logic       P = 1'b0;
  logic [1:0] led;
  logic [1:0] o;
  logic [1:0] credit;
  logic       busy;
  logic       coin_rej;
`ifdef VEND_CHANGE_EN
  logic       R = 1'b0;
  logic       chg;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model: credit, wanted products, what is dispensing and for
  // how long, and which product was served last.
  int m_credit;
  bit m_want_c;
  bit m_want_s;
  int m_disp;
  int m_left;
  int m_last;
  bit m_rej;
  bit pc, pf, pp;

  vend_dispense_ctrl #(
    .COFFEE_PRICE (CP),
    .SPRITE_PRICE (SP),
    .MAX_CREDIT   (MX),
    .DISP_CYCLES  (DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .C        (C),
    .F        (F),
    .P        (P),
`ifdef VEND_CHANGE_EN
    .R        (R),
    .chg      (chg),
`endif
    .led      (led),
    .o        (o),
    .credit   (credit),
    .busy     (busy),
    .coin_rej (coin_rej)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int price(input int g);
    return (g == 1) ? CP : ((g == 2) ? SP : 0);
  endfunction

  task automatic model_reset();
    m_credit = 0;
    m_want_c = 0;
    m_want_s = 0;
    m_disp   = 0;
    m_left   = 0;
    m_last   = 2;
    m_rej    = 0;
    pc = 0; pf = 0; pp = 0;
  endtask

  task automatic model_step(input bit c, input bit f, input bit p);
    bit ce, fe, pe, ok_c, ok_s;
    int old, g;
    ce = c && !pc;
    fe = f && !pf;
    pe = p && !pp;
    old = m_credit;
    g = 0;
    if (m_disp == 0) begin
      ok_c = m_want_c && old >= CP;
      ok_s = m_want_s && old >= SP;
      if (ok_c && ok_s) g = (m_last == 1) ? 2 : 1;
      else if (ok_c)    g = 1;
      else if (ok_s)    g = 2;
      m_want_c = ok_c && g != 1;
      m_want_s = ok_s && g != 2;
    end else begin
      m_left--;
      if (m_left == 0) m_disp = 0;
    end
    m_rej = ce && old == MX;
    m_credit = old + ((ce && old < MX) ? 1 : 0) - price(g);
    if (fe && old >= CP) m_want_c = 1;
    if (pe && old >= SP) m_want_s = 1;
    if (g != 0) begin
      m_disp = g;
      m_left = DC;
      m_last = g;
    end
    pc = c; pf = f; pp = p;
  endtask

  task automatic check_outputs(input string tag);
    int eo, el;
    eo = (m_disp == 1) ? 1 : ((m_disp == 2) ? 2 : 0);
    el = ((m_credit >= SP) ? 2 : 0) + ((m_credit >= CP) ? 1 : 0);
    chk({tag, ".credit"}, 32'(credit), 32'(m_credit));
    chk({tag, ".o"}, 32'(o), 32'(eo));
    chk({tag, ".busy"}, 32'(busy), 32'(m_disp != 0));
    chk({tag, ".coin_rej"}, 32'(coin_rej), 32'(m_rej));
    chk({tag, ".led"}, 32'(led), 32'(el));
  endtask

  task automatic tick(input bit c, input bit f, input bit p);
    C = c; F = f; P = p;
    @(posedge clk);
    model_step(c, f, p);
    #1;
    check_outputs("step");
  endtask

  task automatic do_reset();
    C = 0; F = 0; P = 0;
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic coins(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1, 0, 0);
      tick(0, 0, 0);
    end
  endtask

  initial begin
    int cnt, cnt2, first, both, rej, obad, nchg;

    model_reset();
    do_reset();

    // Two coins then coffee
    coins(2);
    chk("c2_credit", 32'(credit), 32'd2);
    chk("c2_led", 32'(led), 32'd3);
    tick(0, 1, 0);
    tick(0, 0, 0);
    chk("coffee_credit", 32'(credit), 32'd1);
    chk("coffee_led", 32'(led), 32'd1);
    cnt = o[0] ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0);
      if (o[0]) cnt++;
    end
    chk("coffee_len", 32'(cnt), 32'(DC));

    // Both requests together from credit 3
    do_reset();
    coins(3);
    chk("c3_credit", 32'(credit), 32'd3);
    tick(0, 1, 1);
    first = 0; both = 0; cnt = 0; cnt2 = 0;
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 0);
      if (first == 0 && o != 2'b00) first = int'(o);
      if (o == 2'b11) both++;
      if (o[0]) cnt++;
      if (o[1]) cnt2++;
    end
    chk("rr_first", 32'(first), 32'd1);
    chk("rr_both", 32'(both), 32'd0);
    chk("rr_coffee_len", 32'(cnt), 32'(DC));
    chk("rr_sprite_len", 32'(cnt2), 32'(DC));
    chk("rr_credit", 32'(credit), 32'd0);

    // Saturation
    coins(3);
    tick(1, 0, 0);
    rej = coin_rej ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0);
      if (coin_rej) rej++;
    end
    chk("sat_rej", 32'(rej), 32'd1);
    chk("sat_credit", 32'(credit), 32'd3);

    // Unaffordable sprite
    do_reset();
    coins(1);
    tick(0, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    chk("poor_credit", 32'(credit), 32'd1);
    chk("poor_pend", 32'(dut.pend), 32'd0);
    chk("poor_o", 32'(o), 32'd0);

    // Reset during sprite dispense
    coins(1);
    tick(0, 0, 1);
    cnt = 0;
    while (o != 2'b10 && cnt < 10) begin
      tick(0, 0, 0);
      cnt++;
    end
    chk("abort_in_disp", 32'(o), 32'd2);
    tick(0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("abort_o", 32'(o), 32'd0);
    chk("abort_credit", 32'(credit), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));

`ifdef VEND_CHANGE_EN
    // Coin return
    do_reset();
    coins(2);
    R = 1'b1;
    nchg = 0; obad = 0;
    for (int i = 0; i < 8; i++) begin
      F = (i == 2);
      @(posedge clk);
      #1;
      if (chg) nchg++;
      if (o != 2'b00) obad++;
    end
    R = 1'b0;
    F = 1'b0;
    chk("chg_pulses", 32'(nchg), 32'd2);
    chk("chg_credit", 32'(credit), 32'd0);
    chk("chg_no_disp", 32'(obad), 32'd0);
    chk("chg_pend", 32'(dut.pend), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
